// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the RV32I fetch stage: state encodings, NOP encoding and default reset PC.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_imem.sv
// Single-port synchronous-read instruction RAM; a write in the same cycle suppresses the read.
// The array and read register are not reset so the program survives a pipeline reset.
module fetch_unit_imem #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: LOAD/RUN/HALT FSM, PC + redirect mux, load counter, IF/ID register.
// Optional single-step from HALT when FETCH_STEP_EN is defined (adds port i_step).
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned      NB_PC           = 32,
    parameter int unsigned      NB_INSTRUCTION  = 32,
    parameter int unsigned      IMEM_ADDR_WIDTH = 10,
    parameter logic [NB_PC-1:0] RESET_PC        = NB_PC'(RESET_PC_DEFAULT)
) (
    input  logic                       clk,
    input  logic                       i_rst,
    input  logic                       i_stall,
    input  logic                       i_redirect,
    input  logic [NB_PC-1:0]           i_redirect_pc,
    input  logic                       i_halt,
    input  logic                       i_run,
`ifdef FETCH_STEP_EN
    input  logic                       i_step,
`endif
    input  logic                       i_load_start,
    input  logic                       i_load_valid,
    input  logic [NB_INSTRUCTION-1:0]  i_load_data,
    input  logic                       i_load_done,
    output logic                       o_load_ready,
    output logic [IMEM_ADDR_WIDTH:0]   o_load_count,
    output logic [1:0]                 o_state,
    output logic [NB_PC-1:0]           o_fetch_pc,
    output logic [NB_PC-1:0]           o_pc,
    output logic [NB_INSTRUCTION-1:0]  o_instr,
    output logic                       o_valid
);

    localparam logic [IMEM_ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {IMEM_ADDR_WIDTH{1'b0}}};

    state_t                     state_q, state_d;
    logic [NB_PC-1:0]           pc_q, pc_d;
    logic [NB_PC-1:0]           id_pc_q, id_pc_d;
    logic                       valid_q, valid_d;
    logic [IMEM_ADDR_WIDTH:0]   cnt_q, cnt_d;

    logic                       step;
    logic                       run_cycle;
    logic                       fetch;
    logic                       load_ready;
    logic                       load_we;
    logic [NB_PC-1:0]           redirect_pc;
    logic [IMEM_ADDR_WIDTH-1:0] imem_addr;
    logic [NB_INSTRUCTION-1:0]  imem_rdata;

`ifdef FETCH_STEP_EN
    assign step = i_step;
`else
    assign step = 1'b0;
`endif

    assign redirect_pc = i_redirect_pc & ~NB_PC'(3);
    assign load_ready  = (state_q == ST_LOAD) && (cnt_q < DEPTH_CNT);
    assign load_we     = load_ready && i_load_valid && !i_load_start;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        id_pc_d   = id_pc_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        run_cycle = 1'b0;
        fetch     = 1'b0;

        unique case (state_q)
            ST_LOAD: begin
                valid_d = 1'b0;
                if (load_we) begin
                    cnt_d = cnt_q + (IMEM_ADDR_WIDTH+1)'(1);
                end
                if (i_load_start) begin
                    cnt_d = '0;
                end else if (i_load_done) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                end
            end
            ST_RUN: begin
                if (i_load_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                end else if (i_halt) begin
                    // The halting cycle already behaves as a HALT cycle: no fetch.
                    state_d = ST_HALT;
                    valid_d = 1'b0;
                    if (i_redirect) begin
                        pc_d = redirect_pc;
                    end
                end else begin
                    run_cycle = 1'b1;
                end
            end
            ST_HALT: begin
                if (i_load_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                end else begin
                    if (i_run && !i_halt) begin
                        state_d = ST_RUN;
                    end
                    if (step) begin
                        run_cycle = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                        if (i_redirect) begin
                            pc_d = redirect_pc;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
                valid_d = 1'b0;
            end
        endcase

        if (run_cycle) begin
            if (i_redirect) begin
                pc_d    = redirect_pc;
                valid_d = 1'b0;
            end else if (!i_stall) begin
                fetch   = 1'b1;
                id_pc_d = pc_q;
                valid_d = 1'b1;
                pc_d    = pc_q + NB_PC'(4);
            end
        end
    end

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_LOAD;
            pc_q    <= RESET_PC;
            id_pc_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            id_pc_q <= id_pc_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_addr = load_we ? cnt_q[IMEM_ADDR_WIDTH-1:0] : pc_q[IMEM_ADDR_WIDTH+1:2];

    fetch_unit_imem #(
        .DATA_W (NB_INSTRUCTION),
        .ADDR_W (IMEM_ADDR_WIDTH)
    ) u_imem (
        .clk     (clk),
        .we_i    (load_we),
        .re_i    (fetch),
        .addr_i  (imem_addr),
        .wdata_i (i_load_data),
        .rdata_o (imem_rdata)
    );

    // Read register is unreset; any non-valid slot presents NOP instead.
    assign o_instr      = valid_q ? imem_rdata : NB_INSTRUCTION'(NOP_INSTR);
    assign o_valid      = valid_q;
    assign o_pc         = id_pc_q;
    assign o_fetch_pc   = pc_q;
    assign o_state      = state_q;
    assign o_load_count = cnt_q;
    assign o_load_ready = load_ready;

endmodule
